// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg
//  Shared definitions for the shared-UART transmit scheduler: FSM state
//  encoding, default frame payload width and the reference clock / baud
//  figures that the external tick generator is dimensioned from.
//  No ports (package).
package uart_tx_scheduler_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam int unsigned CLK_HZ             = 32'd50_000_000;
    localparam int unsigned BAUD               = 32'd115_200;
    localparam int          DEFAULT_DATA_WIDTH = 32'sd8;

    // Width of the stop-bit counter; it must hold values up to 2
    localparam int          STOP_CNT_W         = 32'sd2;

endpackage : uart_tx_scheduler_pkg

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// uart_tx_scheduler_rr_arbiter
//  Combinational rotate-priority arbiter. The requester at index ptr has the
//  highest priority, followed by ptr+1, ... wrapping at NUM_REQ.
//  Ports:
//   req      in  NUM_REQ    pending requests
//   ptr      in  ID_WIDTH   index of the highest-priority requester
//   en       in  1          arbitration enable; grant is zero when low
//   grant    out NUM_REQ    one-hot grant (all zero when nothing granted)
//   grant_id out ID_WIDTH   index of the granted requester (0 when none)
module uart_tx_scheduler_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                en,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id
);

    // Scan from ptr upward with wrap, taking the first pending request
    always_comb begin
        int  idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        if (en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(ptr) + i;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end else begin
                    idx = idx;
                end
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_id   = ID_WIDTH'(idx);
                    found      = 1'b1;
                end else begin
                    found = found;
                end
            end
        end else begin
            grant    = '0;
            grant_id = '0;
        end
    end

endmodule : uart_tx_scheduler_rr_arbiter

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//  Shares one UART transmit line between NUM_REQ byte producers. A
//  round-robin arbiter picks a requester while idle; its byte is latched and
//  sent as a start bit, DATA_WIDTH data bits (LSB first) and STOP_BITS stop
//  bits, each bit lasting exactly one tx_tick period.
//  Ports:
//   clk       in  1                   system clock
//   reset     in  1                   synchronous active-high reset
//   tx_tick   in  1                   baud strobe, one clk per bit period
//   req       in  NUM_REQ             requester i has a byte pending
//   req_data  in  NUM_REQ*DATA_WIDTH  byte i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack       out NUM_REQ             1-clk pulse: byte latched for requester
//   done      out 1                   1-clk pulse at end of last stop bit
//   done_id   out ID_WIDTH            requester of the frame flagged by done
//   busy      out 1                   high from grant until done
//   tx        out 1                   serial line, idle high
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int STOP_BITS  = 1,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_tick,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          done,
    output logic [ID_WIDTH-1:0]           done_id,
    output logic                          busy,
    output logic                          tx
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [STOP_CNT_W-1:0]   stop_cnt_q, stop_cnt_d;
    logic [ID_WIDTH-1:0]     gid_q, gid_d;
    logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic                    tx_q, tx_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic                    done_q, done_d;
    logic [ID_WIDTH-1:0]     done_id_q, done_id_d;
    logic                    busy_q, busy_d;

    logic                    arb_en_s;
    logic [NUM_REQ-1:0]      arb_grant_s;
    logic [ID_WIDTH-1:0]     arb_id_s;
    logic                    arb_valid_s;
    logic                    bit_last_s;
    logic                    stop_last_s;

    // Arbitration only happens while idle, so a tick or req change during a
    // frame can never disturb the byte already latched.
    assign arb_en_s    = (state_q == ST_IDLE);
    assign arb_valid_s = |arb_grant_s;
    assign bit_last_s  = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1));
    assign stop_last_s = (stop_cnt_q == STOP_CNT_W'(STOP_BITS));

    uart_tx_scheduler_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req      (req),
        .ptr      (ptr_q),
        .en       (arb_en_s),
        .grant    (arb_grant_s),
        .grant_id (arb_id_s)
    );

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            gid_q      <= '0;
            ptr_q      <= '0;
            tx_q       <= 1'b1;
            ack_q      <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            gid_q      <= gid_d;
            ptr_q      <= ptr_d;
            tx_q       <= tx_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; tx_tick is deliberately ignored in IDLE so a tick in
    // the grant cycle cannot shorten the start bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tx_tick && bit_last_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tx_tick && stop_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values. The first tick in STOP raises the
    // line for the first stop bit; each further tick ends one stop bit, and
    // the tick ending the last one reports done.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        gid_d      = gid_q;
        ptr_d      = ptr_q;
        tx_d       = tx_q;
        ack_d      = '0;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (arb_valid_s) begin
                    ack_d   = arb_grant_s;
                    busy_d  = 1'b1;
                    gid_d   = arb_id_s;
                    shift_d = req_data[int'(arb_id_s)*DATA_WIDTH +: DATA_WIDTH];
                    if (arb_id_s == ID_WIDTH'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = arb_id_s + ID_WIDTH'(1);
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_last_s) begin
                        stop_cnt_d = '0;
                    end else begin
                        stop_cnt_d = stop_cnt_q;
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_STOP: begin
                if (tx_tick) begin
                    tx_d = 1'b1;
                    if (stop_last_s) begin
                        done_d    = 1'b1;
                        done_id_d = gid_q;
                        busy_d    = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + STOP_CNT_W'(1);
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign busy    = busy_q;
    assign tx      = tx_q;

endmodule : uart_tx_scheduler

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//  Drives two scheduler instances (1 and 2 stop bits) and compares every
//  clock against a frame model: arbitration as "first pending at/after the
//  rotating pointer", and the line level as a function of how many ticks
//  have elapsed since the grant.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_drv;
    logic        tick_drv;
    logic [3:0]  req_drv;
    logic [31:0] data_drv;
    int          sel;

    logic [3:0]  req_a, req_b;
    logic [3:0]  ack_a, ack_b;
    logic        done_a, done_b, busy_a, busy_b, tx_a, tx_b;
    logic [1:0]  done_id_a, done_id_b;

    assign req_a = (sel == 0) ? req_drv : 4'b0000;
    assign req_b = (sel == 1) ? req_drv : 4'b0000;

    uart_tx_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(rst_drv), .tx_tick(tick_drv), .req(req_a),
        .req_data(data_drv), .ack(ack_a), .done(done_a), .done_id(done_id_a),
        .busy(busy_a), .tx(tx_a)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(rst_drv), .tx_tick(tick_drv), .req(req_b),
        .req_data(data_drv), .ack(ack_b), .done(done_b), .done_id(done_id_b),
        .busy(busy_b), .tx(tx_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int phase = 0;
    int ptr_m [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] o_ack();  return (sel == 1) ? ack_b : ack_a; endfunction
    function automatic logic o_done();       return (sel == 1) ? done_b : done_a; endfunction
    function automatic logic [1:0] o_id();   return (sel == 1) ? done_id_b : done_id_a; endfunction
    function automatic logic o_busy();       return (sel == 1) ? busy_b : busy_a; endfunction
    function automatic logic o_tx();         return (sel == 1) ? tx_b : tx_a; endfunction

    // Round-robin model: first set request at or after the pointer, wrapping
    function automatic int predict(input logic [3:0] mask);
        int g;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (g < 0 && mask[(ptr_m[sel] + i) % 4]) g = (ptr_m[sel] + i) % 4;
        end
        if (g >= 0) ptr_m[sel] = (g + 1) % 4;
        return g;
    endfunction

    // One clock: tick every 16 clocks, outputs sampled at the falling edge
    task automatic step(output bit t);
        t = (phase == 0);
        tick_drv = t;
        @(negedge clk);
        phase = (phase + 1) % 16;
    endtask

    task automatic do_reset();
        bit t;
        rst_drv = 1'b1;
        req_drv = 4'b0000;
        for (int i = 0; i < 3; i++) step(t);
        rst_drv = 1'b0;
        ptr_m[0] = 0;
        ptr_m[1] = 0;
    endtask

    // Send one frame and follow it to done. hold: req stays asserted and no
    // idle gap is inserted (back-to-back). align: grant coincides with a tick.
    // noise: random req activity during the frame, withdrawn before the end.
    task automatic one_frame(input logic [3:0] mask, input bit hold, input bit align, input bit noise);
        bit         t;
        bit         fin;
        int         g, k, sb, idle;
        logic [7:0] d;
        logic [3:0] exp_ack;
        logic       exp_tx;
        sb = (sel == 1) ? 2 : 1;
        if (!hold) begin
            idle = align ? 0 : int'($urandom_range(0, 20));
            for (int i = 0; i < idle; i++) begin
                step(t);
                check_eq("idle_busy", 32'(o_busy()), 32'd0);
                check_eq("idle_tx", 32'(o_tx()), 32'd1);
            end
            while (align && phase != 0) begin
                step(t);
                check_eq("idle_done", 32'(o_done()), 32'd0);
            end
        end
        req_drv = mask;
        g = predict(mask);
        d = data_drv[g*8 +: 8];
        exp_ack = 4'b0001 << g;
        step(t);
        check_eq("grant_ack", 32'(o_ack()), 32'(exp_ack));
        check_eq("grant_busy", 32'(o_busy()), 32'd1);
        check_eq("grant_tx", 32'(o_tx()), 32'd1);
        check_eq("grant_done", 32'(o_done()), 32'd0);
        if (!hold) data_drv = $urandom;
        k = 0;
        fin = 1'b0;
        for (int s = 0; s < 320 && !fin; s++) begin
            if (!hold) req_drv = (noise && k < 8) ? 4'($urandom) : 4'b0000;
            step(t);
            if (t) k++;
            if (k == 0)                exp_tx = 1'b1;
            else if (k == 1)           exp_tx = 1'b0;
            else if (k <= 9)           exp_tx = d[k-2];
            else                       exp_tx = 1'b1;
            check_eq("line", 32'(o_tx()), 32'(exp_tx));
            check_eq("frame_ack", 32'(o_ack()), 32'd0);
            if (k == 10 + sb) begin
                check_eq("done", 32'(o_done()), 32'd1);
                check_eq("done_id", 32'(o_id()), 32'(g));
                check_eq("done_busy", 32'(o_busy()), 32'd0);
                fin = 1'b1;
            end else begin
                check_eq("early_done", 32'(o_done()), 32'd0);
                check_eq("frame_busy", 32'(o_busy()), 32'd1);
            end
        end
        if (!fin) check_eq("frame_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit t;
        int g;
        sel      = 0;
        rst_drv  = 1'b1;
        tick_drv = 1'b0;
        req_drv  = 4'b0000;
        data_drv = 32'h0;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            check_eq("rst_tx", 32'(o_tx()), 32'd1);
            check_eq("rst_ack", 32'(o_ack()), 32'd0);
            check_eq("rst_done", 32'(o_done()), 32'd0);
            check_eq("rst_busy", 32'(o_busy()), 32'd0);
            check_eq("rst_done_id", 32'(o_id()), 32'd0);
        end
        sel = 0;

        // single frame A5 from requester 2
        data_drv = 32'h00A5_0000;
        one_frame(4'b0100, 1'b0, 1'b0, 1'b0);

        // fairness with all requests held, then pointer wrap with 1001
        do_reset();
        data_drv = 32'h1312_1110;
        for (int i = 0; i < 8; i++) one_frame(4'b1111, 1'b1, 1'b0, 1'b0);
        one_frame(4'b1001, 1'b1, 1'b0, 1'b0);
        one_frame(4'b1001, 1'b1, 1'b0, 1'b0);
        req_drv = 4'b0000;

        // tick coinciding with the grant cycle
        data_drv = $urandom;
        one_frame(4'b0010, 1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 20; i++) begin
            data_drv = $urandom;
            one_frame(4'($urandom_range(1, 15)), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        end

        // reset during data bit 4 (payload bit 4 is 0, so the line is low)
        data_drv = 32'h0F0F_0F0F;
        req_drv  = 4'b0100;
        g = predict(4'b0100);
        step(t);
        check_eq("mid_ack", 32'(o_ack()), 32'(4'b0001 << g));
        req_drv = 4'b0000;
        begin
            int k;
            k = 0;
            for (int s = 0; s < 200 && k < 6; s++) begin
                step(t);
                if (t) k++;
            end
            check_eq("mid_reach", 32'(k), 32'd6);
        end
        for (int i = 0; i < 5; i++) step(t);
        check_eq("mid_line_low", 32'(o_tx()), 32'd0);
        rst_drv = 1'b1;
        step(t);
        check_eq("mid_rst_tx", 32'(o_tx()), 32'd1);
        check_eq("mid_rst_busy", 32'(o_busy()), 32'd0);
        check_eq("mid_rst_done", 32'(o_done()), 32'd0);
        check_eq("mid_rst_ack", 32'(o_ack()), 32'd0);
        rst_drv = 1'b0;
        ptr_m[0] = 0;
        ptr_m[1] = 0;
        for (int i = 0; i < 200; i++) begin
            step(t);
            check_eq("post_rst_done", 32'(o_done()), 32'd0);
            check_eq("post_rst_tx", 32'(o_tx()), 32'd1);
        end
        data_drv = $urandom;
        one_frame(4'b1111, 1'b0, 1'b0, 1'b0);

        // two stop bits, all-ones payload, then one random payload
        sel = 1;
        data_drv = 32'hFFFF_FFFF;
        one_frame(4'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b0);
        data_drv = $urandom;
        one_frame(4'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx_scheduler
